// File: rtl/tf520_fastram.sv
// 68020-side Zorro II autoconfig responder and 2MB 32-bit SRAM controller; DSACK after WAITS+1 edges (RAM) or 1 edge (config).
// The cycle holds in ACK until the CPU negates AS20; an early AS20 negation abandons the cycle without DSACK.
module tf520_fastram #(
    parameter logic [15:0] MANUF_ID   = 16'h1455,
    parameter logic [7:0]  PRODUCT_ID = 8'h20,
    parameter int unsigned WAITS      = 1,
    parameter logic [7:0]  ER_TYPE    = 8'hE6
) (
    input  logic        CLKCPU,
    input  logic        RESET,
    input  logic        AS20,
    input  logic        DS20,
    input  logic        RW20,
    input  logic [2:0]  FC,
    input  logic [1:0]  SIZ,
    input  logic [23:0] A,
    input  logic [3:0]  DIN,
    output logic [3:0]  DOUT,
    output logic        DOE,
    output logic        LOCAL,
    output logic        DSACK0,
    output logic        DSACK1,
    output logic        RAMCE,
    output logic        RAMOE,
    output logic [3:0]  RAMWE
);

    typedef enum logic [1:0] {CYC_IDLE, CYC_WAIT, CYC_ACK} cyc_t;
    typedef enum logic [1:0] {AC_UNCONFIG, AC_CONFIGURED, AC_SHUTUP} ac_t;

    cyc_t       cyc_q, cyc_d;
    ac_t        ac_q, ac_d;
    ac_t        pend_q, pend_d;
    logic [2:0] base_q, base_d;
    logic [2:0] pbase_q, pbase_d;
    logic [2:0] cnt_q, cnt_d;
    logic       ram_q, ram_d;
    logic       rd_q, rd_d;

    logic       cpu_space, cfg_hit, ram_hit, ram_act, cfg_rd_ack;
    logic [7:0] rom_byte;
    logic [3:0] nib;
    logic [3:0] lane;
    logic [2:0] len, last;
    logic       unused_din;

    assign unused_din = DIN[0];

    assign cpu_space = (FC == 3'b111);
    assign cfg_hit   = !cpu_space && (A[23:16] == 8'hE8) && (ac_q == AC_UNCONFIG);
    assign ram_hit   = !cpu_space && (ac_q == AC_CONFIGURED) && (A[23:21] == base_q);
    assign LOCAL     = cfg_hit || ram_hit;

    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            cyc_q   <= CYC_IDLE;
            ac_q    <= AC_UNCONFIG;
            pend_q  <= AC_UNCONFIG;
            base_q  <= 3'b000;
            pbase_q <= 3'b000;
            cnt_q   <= 3'd0;
            ram_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            cyc_q   <= cyc_d;
            ac_q    <= ac_d;
            pend_q  <= pend_d;
            base_q  <= base_d;
            pbase_q <= pbase_d;
            cnt_q   <= cnt_d;
            ram_q   <= ram_d;
            rd_q    <= rd_d;
        end
    end

    // Config writes are captured at ACK entry but only take effect when the cycle
    // ends, so LOCAL never drops while the CPU still holds AS20 on that cycle.
    always_comb begin
        cyc_d   = cyc_q;
        ac_d    = ac_q;
        pend_d  = pend_q;
        base_d  = base_q;
        pbase_d = pbase_q;
        cnt_d   = cnt_q;
        ram_d   = ram_q;
        rd_d    = rd_q;
        case (cyc_q)
            CYC_IDLE: begin
                if (!AS20 && LOCAL) begin
                    cyc_d  = CYC_WAIT;
                    ram_d  = ram_hit;
                    rd_d   = RW20;
                    cnt_d  = ram_hit ? 3'(WAITS) : 3'd0;
                    pend_d = AC_UNCONFIG;
                end
            end
            CYC_WAIT: begin
                if (AS20) begin
                    cyc_d = CYC_IDLE;
                end else if (cnt_q == 3'd0) begin
                    cyc_d = CYC_ACK;
                    if (!ram_q && !rd_q) begin
                        if (A[15:0] == 16'h0048) begin
                            pend_d  = AC_CONFIGURED;
                            pbase_d = DIN[3:1];
                        end else if (A[15:0] == 16'h004C) begin
                            pend_d = AC_SHUTUP;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            CYC_ACK: begin
                if (AS20) begin
                    cyc_d  = CYC_IDLE;
                    pend_d = AC_UNCONFIG;
                    if (pend_q != AC_UNCONFIG && ac_q == AC_UNCONFIG) begin
                        ac_d = pend_q;
                        if (pend_q == AC_CONFIGURED) base_d = pbase_q;
                    end
                end
            end
            default: cyc_d = CYC_IDLE;
        endcase
    end

    // Config ROM: one byte per 4-byte slot, high nibble at A[1]=0, inverted past $00.
    always_comb begin
        case (A[6:2])
            5'd0:    rom_byte = ER_TYPE;
            5'd1:    rom_byte = PRODUCT_ID;
            5'd4:    rom_byte = MANUF_ID[15:8];
            5'd5:    rom_byte = MANUF_ID[7:0];
            default: rom_byte = 8'h00;
        endcase
        nib = A[1] ? rom_byte[3:0] : rom_byte[7:4];
        if (A[6:2] != 5'd0) nib = ~nib;
    end

    always_comb begin
        len  = (SIZ == 2'b00) ? 3'd4 : {1'b0, SIZ};
        last = {1'b0, A[1:0]} + len - 3'd1;
        lane = 4'b0000;
        for (int o = 0; o < 4; o++) begin
            lane[3-o] = (3'(o) >= {1'b0, A[1:0]}) && (3'(o) <= last);
        end
    end

    assign ram_act    = (cyc_q != CYC_IDLE) && ram_q;
    assign cfg_rd_ack = (cyc_q == CYC_ACK) && !ram_q && rd_q;

    assign RAMCE  = !ram_act;
    assign RAMOE  = !(ram_act && RW20);
    assign RAMWE  = ~({4{ram_act && !RW20 && !DS20}} & lane);
    assign DSACK1 = !(cyc_q == CYC_ACK);
    assign DSACK0 = !((cyc_q == CYC_ACK) && ram_q);
    assign DOE    = cfg_rd_ack;
    assign DOUT   = cfg_rd_ack ? nib : 4'h0;

endmodule

// File: tb/tb_tf520_fastram.sv
// Bench for tf520_fastram: randomized 68020 cycles against a behavioural bus model,
// acknowledged cycles checked by a DSACK-driven scoreboard monitor.
module tb_tf520_fastram;
    localparam int WAITS = 1;

    logic        CLKCPU = 1'b0;
    logic        RESET  = 1'b0;
    logic        AS20   = 1'b1;
    logic        DS20   = 1'b1;
    logic        RW20   = 1'b1;
    logic [2:0]  FC     = 3'b101;
    logic [1:0]  SIZ    = 2'b00;
    logic [23:0] A      = 24'h0;
    logic [3:0]  DIN    = 4'h0;
    logic [3:0]  DOUT;
    logic        DOE, LOCAL, DSACK0, DSACK1, RAMCE, RAMOE;
    logic [3:0]  RAMWE;

    tf520_fastram #(.MANUF_ID(16'h1455), .PRODUCT_ID(8'h20), .WAITS(WAITS), .ER_TYPE(8'hE6)) dut (
        .CLKCPU(CLKCPU), .RESET(RESET), .AS20(AS20), .DS20(DS20), .RW20(RW20), .FC(FC),
        .SIZ(SIZ), .A(A), .DIN(DIN), .DOUT(DOUT), .DOE(DOE), .LOCAL(LOCAL),
        .DSACK0(DSACK0), .DSACK1(DSACK1), .RAMCE(RAMCE), .RAMOE(RAMOE), .RAMWE(RAMWE)
    );

    always #5 CLKCPU = ~CLKCPU;

    int vectors = 0;
    int miscompares = 0;
    int cyc_n = 0;
    int cfg_st = 0;            // 0 unconfigured, 1 configured, 2 shut up
    logic [2:0] base = 3'b000;

    typedef struct {
        int         end_cyc;
        logic       d0;
        logic       doe;
        logic [3:0] dout;
        logic       ce;
        logic       oe;
        logic [3:0] we;
    } exp_t;
    exp_t sb[$];

    always @(posedge CLKCPU) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, req, $time);
        end
    endtask

    // Reference model: Zorro config bytes, nibble placement and inversion.
    function automatic logic [7:0] rom_ref(input int boff);
        case (boff)
            0:       return 8'hE6;
            4:       return 8'h20;
            16:      return 8'h14;
            20:      return 8'h55;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [3:0] nib_ref(input logic [23:0] a);
        int off;
        logic [7:0] b;
        logic [3:0] n;
        off = int'(a[6:0]);
        b = rom_ref(off - (off % 4));
        n = ((off % 4) >= 2) ? b[3:0] : b[7:4];
        return (off >= 4) ? ~n : n;
    endfunction

    function automatic logic [3:0] lanes_ref(input logic [1:0] a10, input logic [1:0] siz);
        int len, lo, hi;
        logic [3:0] m;
        len = (siz == 2'b00) ? 4 : int'(siz);
        lo = int'(a10);
        hi = (lo + len - 1 > 3) ? 3 : lo + len - 1;
        m = 4'b0000;
        for (int o = lo; o <= hi; o++) m[3-o] = 1'b1;
        return m;
    endfunction

    function automatic logic local_ref(input logic [2:0] fc, input logic [23:0] a);
        if (fc == 3'b111) return 1'b0;
        if (cfg_st == 0) return a[23:16] == 8'hE8;
        if (cfg_st == 1) return a[23:21] == base;
        return 1'b0;
    endfunction

    // Monitor: every falling DSACK1 must match the oldest expected response.
    logic prev_d1 = 1'b1;
    exp_t mon_e;
    always @(posedge CLKCPU) begin
        #1;
        if (!DSACK1 && prev_d1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_dsack: DSACK1 low with nothing expected at t=%0t", $time);
            end else begin
                mon_e = sb.pop_front();
                check("ack_resp",
                      {4'h0, 16'(cyc_n), DSACK0, DOE, DOUT, RAMCE, RAMOE, RAMWE},
                      {4'h0, 16'(mon_e.end_cyc), mon_e.d0, mon_e.doe, mon_e.dout, mon_e.ce, mon_e.oe, mon_e.we});
            end
        end
        prev_d1 = DSACK1;
    end

    task automatic do_cycle(input logic [2:0] fc, input logic [23:0] a, input logic rw,
                            input logic [1:0] siz, input logic [3:0] din);
        logic hit, ram;
        exp_t e;
        int n;
        hit = local_ref(fc, a);
        ram = hit && (cfg_st == 1);
        @(negedge CLKCPU);
        FC = fc; A = a; RW20 = rw; SIZ = siz; DIN = din; AS20 = 1'b0; DS20 = 1'b0;
        if (hit) begin
            e.end_cyc = cyc_n + 2 + (ram ? WAITS : 0);
            e.d0   = !ram;
            e.doe  = !ram && rw;
            e.dout = (!ram && rw) ? nib_ref(a) : 4'h0;
            e.ce   = !ram;
            e.oe   = !(ram && rw);
            e.we   = (ram && !rw) ? ~lanes_ref(a[1:0], siz) : 4'hF;
            sb.push_back(e);
        end
        #1 check("local", 32'(LOCAL), 32'(hit));
        if (!hit) begin
            repeat (4) @(negedge CLKCPU);
            check("no_dsack", 32'({DSACK1, RAMCE}), 32'(2'b11));
        end else begin
            n = 0;
            while (DSACK1 && n < 20) begin
                @(negedge CLKCPU);
                n++;
                if (n == 1) check("ramce_at_k", 32'(RAMCE), 32'(!ram));
            end
            if (DSACK1) begin
                vectors++;
                miscompares++;
                $display("FAIL dsack_timeout: DSACK1 still 1 after 20 cycles, need 0, addr %h", a);
            end
        end
        @(negedge CLKCPU);
        AS20 = 1'b1; DS20 = 1'b1;
        @(negedge CLKCPU);
        check("release", 32'({DSACK0, DSACK1, RAMCE, RAMOE, DOE}), 32'(5'b11110));
        if (hit && !ram && !rw) begin
            if (a[15:0] == 16'h0048) begin cfg_st = 1; base = din[3:1]; end
            else if (a[15:0] == 16'h004C) cfg_st = 2;
        end
    endtask

    initial begin
        #300000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        logic bad;
        repeat (2) @(negedge CLKCPU);
        check("reset_outs", 32'({DSACK0, DSACK1, RAMCE, RAMOE, RAMWE, DOE, DOUT}), 32'(13'b1111_1111_0_0000));
        RESET = 1'b1;
        @(negedge CLKCPU);

        // Config ROM reads, CPU space, ignored config write.
        do_cycle(3'b101, 24'hE80000, 1'b1, 2'b00, 4'h0);
        do_cycle(3'b101, 24'hE80002, 1'b1, 2'b00, 4'h0);
        do_cycle(3'b101, 24'hE80004, 1'b1, 2'b00, 4'h0);
        do_cycle(3'b101, 24'hE80006, 1'b1, 2'b00, 4'h0);
        do_cycle(3'b101, 24'hE80040, 1'b1, 2'b00, 4'h0);
        do_cycle(3'b111, 24'hE80000, 1'b1, 2'b00, 4'h0);
        do_cycle(3'b101, 24'hE80050, 1'b0, 2'b00, 4'h9);
        for (int i = 0; i < 10; i++)
            do_cycle(3'b101, {8'hE8, 8'h00, 1'b0, 6'($urandom_range(0, 63)), 1'b0}, 1'b1, 2'b00, 4'h0);
        do_cycle(3'b101, 24'h200000, 1'b1, 2'b00, 4'h0);

        // Configure to $200000 and exercise the RAM window.
        do_cycle(3'b101, 24'hE80048, 1'b0, 2'b00, 4'h2);
        do_cycle(3'b101, 24'h200000, 1'b1, 2'b00, 4'h0);
        do_cycle(3'b001, 24'h3FFFFF, 1'b1, 2'b01, 4'h0);
        do_cycle(3'b101, 24'h400000, 1'b1, 2'b00, 4'h0);
        do_cycle(3'b101, 24'hE80000, 1'b1, 2'b00, 4'h0);
        do_cycle(3'b101, 24'h200002, 1'b0, 2'b01, 4'h0);
        do_cycle(3'b101, 24'h200003, 1'b0, 2'b10, 4'h0);
        do_cycle(3'b111, 24'h200000, 1'b1, 2'b00, 4'h0);
        for (int i = 0; i < 40; i++) begin
            logic [23:0] ra;
            ra = 24'($urandom);
            if ($urandom_range(0, 3) != 0) ra[23:21] = 3'b001;
            do_cycle(3'($urandom_range(0, 7)), ra, 1'($urandom), 2'($urandom), 4'($urandom));
        end

        // Early AS20 negation during WAIT: no DSACK.
        @(negedge CLKCPU);
        FC = 3'b101; A = 24'h210000; RW20 = 1'b1; SIZ = 2'b00; AS20 = 1'b0; DS20 = 1'b0;
        @(negedge CLKCPU);
        check("abort_ce", 32'(RAMCE), 32'(1'b0));
        AS20 = 1'b1; DS20 = 1'b1;
        bad = 1'b0;
        repeat (4) begin
            @(negedge CLKCPU);
            if (!DSACK1 || !DSACK0) bad = 1'b1;
        end
        check("abort_nodsack", 32'({bad, RAMCE}), 32'(2'b01));

        // Reset while in WAIT.
        @(negedge CLKCPU);
        A = 24'h220000; RW20 = 1'b0; SIZ = 2'b00; AS20 = 1'b0; DS20 = 1'b0;
        @(negedge CLKCPU);
        check("wait_ce", 32'({RAMCE, RAMWE}), 32'(5'b0_0000));
        #2 RESET = 1'b0;
        #1 check("async_reset", 32'({DSACK0, DSACK1, RAMCE, RAMOE, RAMWE, DOE, DOUT}), 32'(13'b1111_1111_0_0000));
        cfg_st = 0;
        base = 3'b000;
        AS20 = 1'b1; DS20 = 1'b1;
        @(negedge CLKCPU);
        RESET = 1'b1;
        do_cycle(3'b101, 24'hE80000, 1'b1, 2'b00, 4'h0);
        do_cycle(3'b101, 24'h200000, 1'b1, 2'b00, 4'h0);

        // Shut up: nothing claimed afterwards.
        do_cycle(3'b101, 24'hE8004C, 1'b0, 2'b00, 4'h0);
        do_cycle(3'b101, 24'hE80000, 1'b1, 2'b00, 4'h0);
        do_cycle(3'b101, 24'h000000, 1'b1, 2'b00, 4'h0);
        do_cycle(3'b101, 24'hE80048, 1'b0, 2'b00, 4'h2);

        check("sb_drained", 32'(sb.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
